// File: rtl/cordic_result_collector.sv
// Result collector for the CORDIC core: FWFT circular buffer for core results,
// in-flight job accounting and a credit that keeps every issued job storable.
module cordic_result_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in_interface,
  input  logic             valid_out_interface,
  input  logic [WIDTH-1:0] out_interface,
  input  logic             r_en,
  output logic [WIDTH-1:0] data_r,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level,
  output logic [AW:0]      inflight,
  output logic             credit_ok,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [AW:0]   L_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] L_DEPTH_X  = (AW+2)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [AW:0]      r_inflight;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic [AW+1:0]    w_occupancy;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == L_DEPTH);
  assign w_pop       = r_en && !w_empty;
  assign w_push      = valid_out_interface && (!w_full || w_pop);
  assign w_set_ovf   = valid_out_interface && w_full && !w_pop;
  assign w_set_unf   = (r_en && w_empty) || (valid_out_interface && (r_inflight == '0));
  assign w_occupancy = {1'b0, r_level} + {1'b0, r_inflight};

  // Storage is not reset; only the pointers and level decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= out_interface;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_inflight  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // A result with nothing outstanding is flagged as underflow and leaves inflight at 0.
      if (valid_in_interface && !valid_out_interface) begin
        if (r_inflight != L_DEPTH) r_inflight <= r_inflight + 1'b1;
      end else if (!valid_in_interface && valid_out_interface) begin
        if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
      end

      if (w_set_ovf)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;

      if (w_set_unf)    r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

  assign data_r    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty     = w_empty;
  assign full      = w_full;
  assign level     = r_level;
  assign inflight  = r_inflight;
  assign credit_ok = (w_occupancy < L_DEPTH_X);
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
